// File: rtl/gen2_cmd_framer.sv
// Feeds one Gen2 reader command, MSB-first, into the PIE encoder and appends CRC-5/CRC-16.
// The encoder is released from reset for exactly one frame and returned to reset afterwards.
module gen2_cmd_framer #(
    parameter int MAX_BITS = 128,
    parameter int LEN_W    = $clog2(MAX_BITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [MAX_BITS-1:0] cmd_data,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [1:0]          cmd_crc,
    input  logic                cmd_preamble,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    output logic                enc_rst,
    output logic                enc_bit,
    output logic                enc_preamble,
    input  logic                enc_rdy,
    output logic                busy,
    output logic                done,
    output logic [2:0]          dbg_state_o
);
    // Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
    // enc_bit is consumed on a rising clk edge where enc_rdy is high.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        DATA  = 3'd2,
        CRC   = 3'd3,
        DRAIN = 3'd4
    } state_e;

    localparam logic [1:0] MODE_NONE  = 2'd0;
    localparam logic [1:0] MODE_CRC5  = 2'd1;
    localparam logic [1:0] MODE_CRC16 = 2'd2;

    state_e              state_q, state_d;
    logic [MAX_BITS-1:0] shift_q, shift_d;
    logic [LEN_W-1:0]    data_cnt_q, data_cnt_d;
    logic [15:0]         crc_q, crc_d;
    logic [4:0]          crc_cnt_q, crc_cnt_d;
    logic [1:0]          mode_q, mode_d;
    logic                enc_rst_q, enc_rst_d;
    logic                enc_pre_q, enc_pre_d;
    logic                done_q, done_d;

    logic [LEN_W-1:0]    len_c;
    logic [LEN_W-1:0]    shamt_c;
    logic [1:0]          mode_c;
    logic                accept;
    logic                data_phase;
    logic                data_bit;
    logic                crc_bit;
    logic                fb5;
    logic                fb16;
    logic [4:0]          crc5_upd;
    logic [15:0]         crc16_upd;

    assign len_c      = (cmd_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : cmd_len;
    assign shamt_c    = LEN_W'(MAX_BITS) - len_c;
    assign mode_c     = (cmd_crc == 2'd3) ? MODE_NONE : cmd_crc;
    assign accept     = cmd_valid && cmd_ready;
    assign data_phase = (data_cnt_q != '0);
    assign data_bit   = shift_q[MAX_BITS-1];
    // CRC-16 goes out ones-complemented, CRC-5 as-is.
    assign crc_bit    = (mode_q == MODE_CRC16) ? ~crc_q[15] : crc_q[4];

    assign fb5        = crc_q[4] ^ data_bit;
    assign crc5_upd   = {crc_q[3:0], 1'b0} ^ (fb5 ? 5'b01001 : 5'b00000);
    assign fb16       = crc_q[15] ^ data_bit;
    assign crc16_upd  = {crc_q[14:0], 1'b0} ^ (fb16 ? 16'h1021 : 16'h0000);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        data_cnt_d = data_cnt_q;
        crc_d      = crc_q;
        crc_cnt_d  = crc_cnt_q;
        mode_d     = mode_q;
        enc_pre_d  = enc_pre_q;
        done_d     = 1'b0;
        enc_bit    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d    = cmd_data << shamt_c;
                    data_cnt_d = len_c;
                    mode_d     = mode_c;
                    enc_pre_d  = cmd_preamble;
                    case (mode_c)
                        MODE_CRC5:  begin crc_d = 16'h0009; crc_cnt_d = 5'd5;  end
                        MODE_CRC16: begin crc_d = 16'hFFFF; crc_cnt_d = 5'd16; end
                        default:    begin crc_d = 16'h0000; crc_cnt_d = 5'd0;  end
                    endcase
                    if (len_c == '0 && mode_c == MODE_NONE) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ARM;
                    end
                end
            end
            // ARM already presents the first bit, so it consumes exactly like DATA/CRC.
            ARM, DATA, CRC: begin
                enc_bit = data_phase ? data_bit : crc_bit;
                if (enc_rdy) begin
                    if (data_phase) begin
                        shift_d    = shift_q << 1;
                        data_cnt_d = data_cnt_q - LEN_W'(1);
                        if (mode_q == MODE_CRC5) begin
                            crc_d = {11'b0, crc5_upd};
                        end else if (mode_q == MODE_CRC16) begin
                            crc_d = crc16_upd;
                        end
                        if (data_cnt_q == LEN_W'(1)) begin
                            state_d = (mode_q == MODE_NONE) ? DRAIN : CRC;
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        crc_d     = (mode_q == MODE_CRC5) ? {11'b0, crc_q[3:0], 1'b0}
                                                          : {crc_q[14:0], 1'b0};
                        crc_cnt_d = crc_cnt_q - 5'd1;
                        state_d   = (crc_cnt_q == 5'd1) ? DRAIN : CRC;
                    end
                end
            end
            DRAIN: begin
                if (enc_rdy) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        enc_rst_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            data_cnt_q <= '0;
            crc_q      <= '0;
            crc_cnt_q  <= '0;
            mode_q     <= MODE_NONE;
            enc_rst_q  <= 1'b1;
            enc_pre_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            data_cnt_q <= data_cnt_d;
            crc_q      <= crc_d;
            crc_cnt_q  <= crc_cnt_d;
            mode_q     <= mode_d;
            enc_rst_q  <= enc_rst_d;
            enc_pre_q  <= enc_pre_d;
            done_q     <= done_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
    assign enc_rst      = enc_rst_q;
    assign enc_preamble = enc_pre_q;
    assign done         = done_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_gen2_cmd_framer.sv
// Directed bench for gen2_cmd_framer: an encoder stub strobes enc_rdy and captures enc_bit,
// and captured streams are checked against hand values and CRC residues.
module tb_gen2_cmd_framer;
    localparam int MAX_BITS = 128;
    localparam int LEN_W    = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [MAX_BITS-1:0] cmd_data;
    logic [LEN_W-1:0]    cmd_len;
    logic [1:0]          cmd_crc;
    logic                cmd_preamble;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                enc_rst;
    logic                enc_bit;
    logic                enc_preamble;
    logic                enc_rdy;
    logic                busy;
    logic                done;
    logic [2:0]          dbg_state;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic cap_q[$];
    int   n_strobe;
    logic done_seen;
    int   rst_bad;
    int   rdy_bad;
    logic pre_seen;

    gen2_cmd_framer #(.MAX_BITS(MAX_BITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_data     (cmd_data),
        .cmd_len      (cmd_len),
        .cmd_crc      (cmd_crc),
        .cmd_preamble (cmd_preamble),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .enc_rst      (enc_rst),
        .enc_bit      (enc_bit),
        .enc_preamble (enc_preamble),
        .enc_rdy      (enc_rdy),
        .busy         (busy),
        .done         (done),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] pack(input int k);
        logic [255:0] v = '0;
        for (int i = 0; i < k; i++) v = {v[254:0], (i < cap_q.size()) ? cap_q[i] : 1'bx};
        return v;
    endfunction

    function automatic logic [4:0] crc5_res(input int k);
        logic [4:0] c = 5'b01001;
        logic       fb;
        for (int i = 0; i < k; i++) begin
            fb = c[4] ^ ((i < cap_q.size()) ? cap_q[i] : 1'b0);
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b01001 : 5'b00000);
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_res(input int k);
        logic [15:0] c = 16'hFFFF;
        logic        fb;
        for (int i = 0; i < k; i++) begin
            fb = c[15] ^ ((i < cap_q.size()) ? cap_q[i] : 1'b0);
            c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return c;
    endfunction

    task automatic start_cmd(input logic [MAX_BITS-1:0] d, input logic [LEN_W-1:0] len,
                             input logic [1:0] crc, input logic pre);
        cmd_data     = d;
        cmd_len      = len;
        cmd_crc      = crc;
        cmd_preamble = pre;
        cmd_valid    = 1'b1;
    endtask

    task automatic wait_accept(input bit hold);
        int t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq("accept_wait", (t < 100), 1'b1);
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    // Encoder stub: gap idle cycles, then a one-cycle enc_rdy, capturing the presented bit.
    task automatic run_strobes(input int first_gap, input int gap, input int max_strobes);
        int g;
        n_strobe  = 0;
        done_seen = 1'b0;
        rst_bad   = 0;
        rdy_bad   = 0;
        cap_q.delete();
        g = first_gap;
        while (n_strobe < max_strobes && !done_seen) begin
            repeat (g) begin
                @(negedge clk);
                if (enc_rst !== 1'b0) rst_bad++;
                if (cmd_ready !== 1'b0) rdy_bad++;
            end
            if (n_strobe == 0) pre_seen = enc_preamble;
            cap_q.push_back(enc_bit);
            enc_rdy = 1'b1;
            n_strobe++;
            @(posedge clk);
            #1 enc_rdy = 1'b0;
            @(negedge clk);
            if (done === 1'b1) begin
                done_seen = 1'b1;
            end else begin
                if (enc_rst !== 1'b0) rst_bad++;
                if (cmd_ready !== 1'b0) rdy_bad++;
            end
            g = gap;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cmd_data = '0; cmd_len = '0; cmd_crc = 2'd0; cmd_preamble = 1'b0;
        cmd_valid = 1'b0; enc_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_enc_rst", enc_rst, 1'b1);
        check_eq("rst_cmd_ready", cmd_ready, 1'b1);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_enc_pre", enc_preamble, 1'b0);
        check_eq("rst_enc_bit", enc_bit, 1'b0);
        check_eq("rst_state", dbg_state, 3'd0);

        // QueryRep
        start_cmd(128'h1, 8'd4, 2'd0, 1'b0);
        wait_accept(0);
        run_strobes(8, 1, 40);
        check_eq("qrep_strobes", n_strobe, 5);
        check_eq("qrep_done_lat", done_seen, 1'b1);
        check_eq("qrep_bits", pack(4), 4'b0001);
        check_eq("qrep_enc_rst_low", rst_bad, 0);
        check_eq("qrep_pre", pre_seen, 1'b0);
        @(negedge clk);
        check_eq("qrep_done_pulse", {done, enc_rst, busy}, 3'b010);

        // ACK with RN16
        start_cmd(128'h1A5C3, 8'd18, 2'd0, 1'b0);
        wait_accept(0);
        run_strobes(6, 2, 60);
        check_eq("ack_strobes", n_strobe, 19);
        check_eq("ack_bits", pack(18), 18'h1A5C3);
        check_eq("ack_enc_rst_low", rst_bad, 0);

        // Query with CRC-5 and full preamble
        start_cmd(128'h10A35, 8'd17, 2'd1, 1'b1);
        wait_accept(0);
        run_strobes(10, 1, 60);
        check_eq("query_strobes", n_strobe, 23);
        check_eq("query_data", pack(17), 17'h10A35);
        check_eq("query_crc5_res", crc5_res(22), 5'b00000);
        check_eq("query_pre", pre_seen, 1'b1);

        // CRC-16 command
        start_cmd(128'hC35A960FE1, 8'd40, 2'd2, 1'b0);
        wait_accept(0);
        run_strobes(5, 0, 100);
        check_eq("crc16_strobes", n_strobe, 57);
        check_eq("crc16_data", pack(40), 40'hC35A960FE1);
        check_eq("crc16_res", crc16_res(56), 16'h1D0F);

        // CRC mode 3 behaves as no CRC
        start_cmd(128'hA, 8'd4, 2'd3, 1'b0);
        wait_accept(0);
        run_strobes(3, 1, 40);
        check_eq("mode3_strobes", n_strobe, 5);
        check_eq("mode3_bits", pack(4), 4'hA);

        // Length above MAX_BITS clamps
        start_cmd({1'b1, 126'b0, 1'b1}, 8'd200, 2'd0, 1'b0);
        wait_accept(0);
        run_strobes(3, 0, 200);
        check_eq("clamp_strobes", n_strobe, 129);
        check_eq("clamp_bits", pack(128), {1'b1, 126'b0, 1'b1});

        // Back-to-back with cmd_valid held
        start_cmd(128'hC5, 8'd8, 2'd0, 1'b0);
        wait_accept(1);
        cmd_data = 128'h3C;
        cmd_len  = 8'd6;
        run_strobes(4, 1, 40);
        check_eq("b2b_a_strobes", n_strobe, 9);
        check_eq("b2b_a_bits", pack(8), 8'hC5);
        check_eq("b2b_a_ready_low", rdy_bad, 0);
        check_eq("b2b_gap", {enc_rst, cmd_ready, done}, 3'b111);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        run_strobes(4, 1, 40);
        check_eq("b2b_b_strobes", n_strobe, 7);
        check_eq("b2b_b_bits", pack(6), 6'h3C);
        check_eq("b2b_b_enc_rst_low", rst_bad, 0);

        // Reset mid-frame at bit 7
        start_cmd(128'h1234, 8'd16, 2'd2, 1'b1);
        wait_accept(0);
        run_strobes(3, 1, 7);
        check_eq("mid_strobes", n_strobe, 7);
        check_eq("mid_in_data", dbg_state, 3'd2);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("mid_rst_hold", {enc_rst, busy, cmd_ready, done}, 4'b1010);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("mid_no_done", {done, enc_rst}, 2'b01);
        start_cmd(128'h16, 8'd5, 2'd1, 1'b1);
        wait_accept(0);
        run_strobes(8, 1, 40);
        check_eq("post_strobes", n_strobe, 11);
        check_eq("post_bits", pack(5), 5'b10110);
        check_eq("post_crc5_res", crc5_res(10), 5'b00000);
        check_eq("post_enc_rst_low", rst_bad, 0);

        // Zero length, no CRC
        @(negedge clk);
        start_cmd(128'h0, 8'd0, 2'd0, 1'b0);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("zero_done", {done, enc_rst, busy}, 3'b110);
        @(negedge clk);
        check_eq("zero_after", {done, enc_rst, busy}, 3'b010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/gen2_cmd_framer.md
Name: gen2_cmd_framer

Overview:
- Upstream feeder for the team's PIE encoder.
- Accepts one complete Gen2 reader command as a parallel word plus length over a valid/ready handshake.
- Gates the encoder out of reset so it emits delimiter and preamble or frame-sync. Serialises the command bits MSB-first on the encoder's ready strobe, generates and appends CRC-5 or CRC-16 on the fly, then returns the encoder to reset, which holds the line at CW.

Parameters:
- MAX_BITS, 128, widest command payload in bits, excluding CRC.
- LEN_W, $clog2(MAX_BITS+1), width of the length field.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cmd_data  in  MAX_BITS  command bits; bit cmd_len-1 is transmitted first
- cmd_len  in  LEN_W  payload bit count, 0..MAX_BITS
- cmd_crc  in  2  CRC mode: 0 = none, 1 = CRC-5, 2 = CRC-16, 3 = treated as none
- cmd_preamble  in  1  1 = full preamble (TRCAL sent), 0 = frame-sync
- cmd_valid  in  1  command offered
- cmd_ready  out  1  framer can accept a command
- enc_rst  out  1  registered reset to the PIE encoder; 1 holds the encoder idle with output high
- enc_bit  out  1  bit presented to the encoder; combinational from the shift state
- enc_preamble  out  1  registered copy of cmd_preamble, driven to the encoder preamble select
- enc_rdy  in  1  encoder strobe; enc_bit is consumed on the cycle this is high
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse when a frame completes and the encoder is back in reset

Behaviour:
- Reset values: enc_rst=1, cmd_ready=1, busy=0, done=0, enc_preamble=0, enc_bit=0, state IDLE. Bit counter, shift register and CRC register are all cleared.
- A command is accepted on a clk edge where cmd_valid && cmd_ready. On acceptance the framer latches:
  - cmd_data, left-aligned so the first bit sits at the MSB;
  - cmd_len and the CRC mode;
  - cmd_preamble into enc_preamble.
- CRC register preset on acceptance:
  - CRC-5: 5'b01001.
  - CRC-16: 16'hFFFF.
- Total bits = cmd_len + 0, 5 or 16 according to CRC mode.
- If total bits = 0: stay in IDLE, keep enc_rst=1, pulse done on the next cycle.
- States:
  - IDLE: cmd_ready=1, enc_rst=1, busy=0. On accept -> ARM.
  - ARM: enc_rst deasserts on the registered transition into ARM; cmd_ready=0, busy=1. Wait for enc_rdy. The encoder is emitting delimiter, sync and calibration symbols during this time.
    - The first enc_rdy consumes data bit 0 (or CRC bit 0 if cmd_len=0) -> DATA or CRC.
    - enc_bit in ARM already presents that first bit.
  - DATA: enc_bit = shift MSB.
    - On enc_rdy: shift left, decrement the remaining-data count, update the CRC with the consumed bit.
    - CRC-5: poly x^5+x^3+1, feedback = crc[4]^bit.
    - CRC-16: CCITT poly 0x1021, feedback = crc[15]^bit.
    - When the last data bit is consumed: go to CRC if mode is not none, else DRAIN.
  - CRC: enc_bit = CRC MSB. For CRC-16 the bit is inverted, so the ones-complement is sent. For CRC-5 it is sent uncomplemented.
    - On enc_rdy: shift the CRC register left.
    - After 5 or 16 bits -> DRAIN.
  - DRAIN: enc_bit=0, as a don't-care. The next enc_rdy marks the end of the final symbol.
    - On that edge: -> IDLE, enc_rst=1 registered on the same edge, done=1 for one cycle.
    - The encoder may show one cycle of the next symbol's high level before reset; the line stays high, which is acceptable.
- enc_rdy is ignored in IDLE. cmd_valid is ignored while busy.
- No timeout exists: if the encoder stalls, the framer stays in its current state.
- Reset mid-frame: all state returns to reset values immediately (asynchronous) and enc_rst=1 forces the line to CW. No done pulse is produced and the command is discarded.
- cmd_len > MAX_BITS is clamped to MAX_BITS.

Test Plan:
- QueryRep: cmd_len=4, data=4'b0001, crc=0, preamble=0, paired with the PIE encoder.
  - Line shows delimiter, data-0, RTCAL, then symbols 0,0,0,1 (no TRCAL), then high.
  - done pulses once, exactly 1 cycle after the 5th enc_rdy.
- ACK: cmd_len=18, data=2'b01 followed by RN16 16'hA5C3, crc=0.
  - Exactly 18 enc_rdy strobes consume bits in MSB-first order; a 19th strobe ends DRAIN.
  - enc_rst stays 0 from ARM until DRAIN exits.
- Query: cmd_len=17, crc=1, preamble=1.
  - The captured 22-bit stream, run through a CRC-5 checker with preset 01001, leaves residue 5'b00000.
  - TRCAL is present on the line.
- CRC-16 command: cmd_len=40, random data, crc=2.
  - The 56 captured bits, run through a CRC-16 checker with preset FFFF, leave residue 16'h1D0F.
- Back-to-back commands: cmd_valid held high with two commands.
  - cmd_ready=0 throughout frame 1; the second is accepted only in IDLE after done.
  - enc_rst is high for at least 1 cycle between frames.
- Reset mid-frame: assert rst during DATA at bit 7, release after 3 cycles.
  - enc_rst=1, busy=0, cmd_ready=1 and done=0 are held while rst is high.
  - A new command afterwards frames correctly from a fresh delimiter.
- Zero-length, no CRC: cmd_len=0, crc=0.
  - enc_rst never deasserts; done pulses 1 cycle after accept.
